// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of one shared UART byte transmitter, granted a whole packet at a time.
// Bytes are paced by a one-cycle tx_start and the transmitter's tx_active flag; stalled owners time out.
module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   byte_valid,
  input  logic [8*N_REQ-1:0] byte_data,
  input  logic [N_REQ-1:0]   byte_last,
  output logic [N_REQ-1:0]   byte_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_byte,
  output logic               tx_start,
  input  logic               tx_active,
  output logic               busy,
  output logic               pkt_done,
  output logic               pkt_timeout
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACT, WAIT_DONE, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    own_q, own_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win, cand;
  logic             win_ok;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             in_load;

  // The nearest requester at or after ptr wins; scanning from the far end lets the nearest overwrite.
  always_comb begin
    win    = ptr_q;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k >= N_REQ) ? IW'(int'(ptr_q) + k - N_REQ) : IW'(int'(ptr_q) + k);
      if (req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  assign in_load    = (state_q == LOAD);
  assign byte_ready = in_load ? (byte_valid & grant_q) : '0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_ok) begin
          grant_d = N_REQ'(1) << win;
          own_d   = win;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (byte_valid[own_q]) begin
          tx_byte_d = byte_data[8*own_q +: 8];
          last_d    = byte_last[own_q];
          start_d   = 1'b1;
          state_d   = WAIT_ACT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CW'(TIMEOUT_CYCLES - 1)) ? RELEASE : LOAD;
        end
      end
      WAIT_ACT:  state_d = tx_active ? WAIT_DONE : WAIT_ACT;
      WAIT_DONE: begin
        if (!tx_active) begin
          cnt_d   = last_q ? cnt_q : '0;
          state_d = last_q ? RELEASE : LOAD;
        end
      end
      RELEASE: begin
        // last_q is cleared at grant, so a release without a last byte can only be a timeout.
        grant_d = '0;
        ptr_d   = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
        done_d  = last_q;
        tmo_d   = !last_q;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      last_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      last_q    <= last_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign tx_byte     = tx_byte_q;
  assign tx_start    = start_q;
  assign busy        = busy_q;
  assign pkt_done    = done_q;
  assign pkt_timeout = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a simple transmitter model (3-cycle busy).
module tb_uart_tx_arbiter;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  byte_valid = '0;
  logic [1:0]  byte_last = '0;
  logic [15:0] byte_data = '0;
  logic [1:0]  byte_ready, grant;
  logic [7:0]  tx_byte;
  logic        tx_start, tx_active, busy, pkt_done, pkt_timeout;
  logic [2:0]  tcnt = '0;
  logic        prev_act = 1'b0;
  int          tests = 0, fails = 0, cyc = 0, fall_cyc = 0, ndone = 0, ntmo = 0;
  int          g_cyc, nstart, t;
  logic [7:0]  log_q[$];
  logic [7:0]  exp_rr [8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .grant(grant), .tx_byte(tx_byte),
    .tx_start(tx_start), .tx_active(tx_active), .busy(busy), .pkt_done(pkt_done),
    .pkt_timeout(pkt_timeout)
  );

  always #5 Clk = ~Clk;

  // Transmitter: idle one cycle after the start pulse, then busy for three cycles.
  always @(posedge Clk) begin
    cyc  <= cyc + 1;
    tcnt <= tx_start ? 3'd4 : (tcnt != 3'd0 ? tcnt - 3'd1 : 3'd0);
  end
  assign tx_active = (tcnt != 3'd0) && (tcnt != 3'd4);

  always @(negedge Clk) begin
    if (tx_start) begin
      log_q.push_back(tx_byte);
      tests++;
      assert (tx_active === 1'b0) else begin
        fails++;
        $error("FAIL start_while_active: tx_active=%b required 0", tx_active);
      end
    end
    if (pkt_done) ndone++;
    if (pkt_timeout) ntmo++;
    if (prev_act && !tx_active) fall_cyc = cyc;
    prev_act = tx_active;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst_n = 1'b0;
    req = '0;
    byte_valid = '0;
    byte_last = '0;
    byte_data = '0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  task automatic send(input logic ln, input logic [7:0] d, input logic l);
    int n = 0;
    byte_valid[ln] = 1'b1;
    byte_data[8*ln +: 8] = d;
    byte_last[ln] = l;
    #1;
    while (!byte_ready[ln] && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(n < 100), 1);
    @(posedge Clk);
    #1;
    byte_valid[ln] = 1'b0;
    chk("tx_start", 32'(tx_start), 1);
    chk("tx_byte", 32'(tx_byte), 32'(d));
    tick();
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!pkt_done && !pkt_timeout && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_end_wait"}, 32'(n < 100), 1);
  endtask

  initial begin
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(pkt_done), 0);
    chk("rst_timeout", 32'(pkt_timeout), 0);

    // Single requester, three-byte packet, req dropped after the first byte.
    log_q.delete();
    ndone = 0;
    ntmo = 0;
    req = 2'b01;
    tick();
    chk("s_grant", 32'(grant), 1);
    chk("s_busy", 32'(busy), 1);
    send(1'b0, 8'h41, 1'b0);
    req = 2'b00;
    chk("s_hold_grant", 32'(grant), 1);
    send(1'b0, 8'h3D, 1'b0);
    chk("s_hold_grant2", 32'(grant), 1);
    send(1'b0, 8'h0D, 1'b1);
    wait_end("s");
    chk("s_done", 32'(pkt_done), 1);
    chk("s_no_tmo", 32'(pkt_timeout), 0);
    chk("s_grant_rel", 32'(grant), 0);
    chk("s_busy_rel", 32'(busy), 0);
    chk("s_done_lat", cyc - fall_cyc, 2);
    tick();
    chk("s_done_cnt", ndone, 1);
    chk("s_tmo_cnt", ntmo, 0);
    chk("s_nbytes", log_q.size(), 3);
    chk("s_b0", 32'(log_q[0]), 32'h41);
    chk("s_b1", 32'(log_q[1]), 32'h3D);
    chk("s_b2", 32'(log_q[2]), 32'h0D);

    // Contention: four packets alternate 01,10,01,10; lane 1 presents a byte while lane 0 owns.
    do_reset();
    log_q.delete();
    byte_valid[1] = 1'b1;
    byte_data[15:8] = 8'hB0;
    req = 2'b11;
    tick();
    chk("rr_g1", 32'(grant), 1);
    chk("rr_ready_masked", 32'(byte_ready), 0);
    send(1'b0, 8'hA0, 1'b0);
    send(1'b0, 8'hA1, 1'b1);
    wait_end("rr1");
    tick();
    chk("rr_g2", 32'(grant), 2);
    send(1'b1, 8'hB0, 1'b0);
    send(1'b1, 8'hB1, 1'b1);
    wait_end("rr2");
    tick();
    chk("rr_g3", 32'(grant), 1);
    send(1'b0, 8'hC0, 1'b0);
    send(1'b0, 8'hC1, 1'b1);
    wait_end("rr3");
    tick();
    chk("rr_g4", 32'(grant), 2);
    req = 2'b00;
    send(1'b1, 8'hD0, 1'b0);
    send(1'b1, 8'hD1, 1'b1);
    wait_end("rr4");
    tick();
    chk("rr_idle_grant", 32'(grant), 0);
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_nbytes", log_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(log_q[i]), 32'(exp_rr[i]));

    // Fairness: requester 1 first, requester 0 joins and is served next.
    do_reset();
    req = 2'b10;
    tick();
    chk("f_g1", 32'(grant), 2);
    req = 2'b11;
    send(1'b1, 8'h51, 1'b1);
    wait_end("f1");
    tick();
    chk("f_g0_next", 32'(grant), 1);
    req = 2'b00;
    send(1'b0, 8'h52, 1'b1);
    wait_end("f2");
    do_reset();
    req = 2'b11;
    tick();
    chk("f_rst_prio", 32'(grant), 1);
    req = 2'b00;
    send(1'b0, 8'h53, 1'b1);
    wait_end("f3");

    // Timeout with TIMEOUT_CYCLES=8: requester 0 never supplies a byte.
    do_reset();
    ndone = 0;
    ntmo = 0;
    nstart = log_q.size();
    req = 2'b11;
    tick();
    chk("t_grant", 32'(grant), 1);
    g_cyc = cyc;
    wait_end("t");
    chk("t_pulse", 32'(pkt_timeout), 1);
    chk("t_no_done", 32'(pkt_done), 0);
    chk("t_latency", cyc - g_cyc, 8);
    chk("t_grant_rel", 32'(grant), 0);
    chk("t_no_start", log_q.size(), nstart);
    tick();
    chk("t_next_grant", 32'(grant), 2);
    req = 2'b00;
    send(1'b1, 8'h77, 1'b1);
    wait_end("t2");
    chk("t2_done", 32'(pkt_done), 1);
    tick();
    chk("t_tmo_cnt", ntmo, 1);
    chk("t_done_cnt", ndone, 1);

    // Reset while the second byte is on the wire, then a clean restart.
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b00;
    send(1'b0, 8'h61, 1'b0);
    send(1'b0, 8'h62, 1'b0);
    t = 0;
    while (!tx_active && t < 50) begin
      tick();
      t++;
    end
    chk("r_active_wait", 32'(t < 50), 1);
    tick();
    Rst_n = 1'b0;
    tick();
    chk("r_grant", 32'(grant), 0);
    chk("r_tx_byte", 32'(tx_byte), 0);
    chk("r_tx_start", 32'(tx_start), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(pkt_done), 0);
    chk("r_tmo", 32'(pkt_timeout), 0);
    Rst_n = 1'b1;
    t = 0;
    while (tx_active && t < 50) begin
      tick();
      t++;
    end
    chk("r_idle_wait", 32'(t < 50), 1);
    log_q.delete();
    ndone = 0;
    req = 2'b01;
    tick();
    chk("r_regrant", 32'(grant), 1);
    req = 2'b00;
    send(1'b0, 8'h41, 1'b1);
    wait_end("r");
    chk("r_pkt_done", 32'(pkt_done), 1);
    tick();
    chk("r_nbytes", log_q.size(), 1);
    chk("r_byte", 32'(log_q[0]), 32'h41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART byte transmitter between up to N_REQ packet sources, e.g. the classification-result reporter and a debug/heartbeat reporter. It grants the transmitter to one requester at a time by round-robin. It holds the grant for a whole packet, terminated by a byte flagged `last`. It paces bytes to the transmitter with a one-cycle start pulse and the transmitter's active flag, and releases stalled owners after a timeout.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, default 1024: consecutive idle cycles in LOAD before a forced release, legal range ≥2.

Ports:
- `Clk`  in  1  single clock, all logic on rising edge.
- `Rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  requester wants the transmitter for one packet; sampled only in IDLE.
- `byte_valid`  in  N_REQ  requester has a byte on its lane.
- `byte_data`  in  8*N_REQ  byte lanes; lane i = bits [8i+7:8i].
- `byte_last`  in  N_REQ  current byte is the final byte of the packet.
- `byte_ready`  out  N_REQ  combinational; byte accepted on this edge.
- `grant`  out  N_REQ  registered, one-hot or zero; current owner.
- `tx_byte`  out  8  registered byte to the transmitter.
- `tx_start`  out  1  registered one-cycle start pulse to the transmitter.
- `tx_active`  in  1  transmitter busy flag; rises ≥1 cycle after `tx_start`, falls when the stop bit ends.
- `busy`  out  1  registered; high in every state except IDLE.
- `pkt_done`  out  1  one-cycle pulse; packet ended normally.
- `pkt_timeout`  out  1  one-cycle pulse; packet ended by timeout.

## Operation
- Reset values: `grant`=0, `tx_byte`=0, `tx_start`=0, `busy`=0, `pkt_done`=0, `pkt_timeout`=0, state IDLE, rr pointer=0 (requester 0 has highest priority), timeout counter=0, last flag=0.
- Round-robin: the search starts at index `ptr` and wraps modulo N_REQ; the first requester with `req` set wins. On release, `ptr` is set to winner+1 mod N_REQ. This applies to both normal and timeout releases.
- IDLE: if `req`≠0, register the winner into `grant`, clear the timeout counter, go to LOAD. Otherwise stay in IDLE.
- LOAD: `byte_ready[g]` = `byte_valid[g]`; all other bits of `byte_ready` are 0.
  - On valid: latch `byte_data` lane g into `tx_byte`, latch `byte_last[g]`, assert `tx_start` for the next cycle only, go to WAIT_ACT.
  - Otherwise: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, go to RELEASE and flag a timeout.
- WAIT_ACT: `tx_start`=0. Wait for `tx_active`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_active`=0.
  - If the latched last flag is set: go to RELEASE (normal).
  - Otherwise: clear the timeout counter and go to LOAD.
- RELEASE: `grant`←0, update `ptr`, pulse `pkt_done` or `pkt_timeout` (never both), go to IDLE.
- Sources lanes not granted are ignored entirely: `byte_valid`, `byte_data` and `byte_last` on those lanes have no effect.
- `req` deasserting mid-packet does not release the grant. Only `last` or a timeout ends ownership.
- `req` still high at RELEASE makes that requester eligible again. It is served after the other pending requesters.
- Timeout width: counter is $clog2(TIMEOUT_CYCLES) bits, saturating-safe, and counts only in LOAD.

## Timing
- Grant latency: `req` seen in IDLE at edge k gives `grant` at k+1. The earliest `byte_ready` is in cycle k+1.
- Byte accepted at edge m gives `tx_start`=1 and `tx_byte` valid for exactly cycle m+1. The byte is held until the next accept.
- Inter-byte gap: the next `byte_ready` can occur no earlier than one cycle after `tx_active` falls.
- Packet end: `tx_active` falls at edge n on the last byte. `pkt_done` and `grant`=0 appear at n+2, `busy`=0 at n+2, and a new `grant` at n+3 at the earliest.
- Timeout: `pkt_timeout` and the release occur exactly TIMEOUT_CYCLES cycles after entry to LOAD with no valid byte.
- `tx_start` is never asserted while `tx_active`=1.
- Reset mid-operation, including mid-byte: all outputs return to their reset values on the next edge. The in-flight serial byte is the transmitter's concern; the arbiter does not re-send it.

## Test plan
- Single requester: `req`=01, 3-byte packet 0x41,0x3D,0x0D with `last` on 0x0D → three `tx_start` pulses carrying those bytes, each issued only after `tx_active` has fallen; one `pkt_done`; `grant` 01→00.
- Contention and round-robin: `req`=11 held for two packets each → grant order 01,10,01,10. Bytes are never interleaved between packets.
- Fairness after reset: `req`=10, then `req`=11 while requester 1 owns → requester 0 is granted next. `ptr` after reset selects requester 0 first when both request simultaneously.
- Timeout (TIMEOUT_CYCLES=8): grant requester 0, never assert `byte_valid` → `pkt_timeout` pulse exactly 8 cycles after LOAD entry, no `tx_start`, and requester 1 is granted next if requesting.
- Reset mid-packet: `Rst_n`=0 during WAIT_DONE of byte 2 → next cycle all outputs are 0 and state is IDLE. After release, `req`=01 restarts cleanly with byte 1.
- `req` drop mid-packet: requester deasserts `req` after byte 1 → grant is held until the `last` byte, then `pkt_done`.
